// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states and width constants.
package div_pkg;

    localparam int DEF_WIDTH = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_unit_if.sv
// Control-unit <-> divider bundle: level-held control, operands, HI/LO results and status.
interface div_unit_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             control;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic             done;
    logic             div0;

    modport master (
        output control, in0, in1,
        input  out0, out1, done, div0
    );

    modport slave (
        input  control, in0, in1,
        output out0, out1, done, div0
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits, and shift the resulting quotient bit into Q.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] t;
    logic           fits;

    // The true difference is always below D, so a WIDTH-bit subtract is exact.
    always_comb begin
        t      = {r, q[WIDTH-1]};
        fits   = (t >= {1'b0, d});
        r_next = fits ? (t[WIDTH-1:0] - d) : t[WIDTH-1:0];
        q_next = {q[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider (DIV semantics): remainder to out0 (HI), quotient to out1 (LO),
// one restoring step per cycle on operand magnitudes, sign fix-up in a final cycle.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic       clk,
    input logic       reset,
    div_unit_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t state, state_next;

    logic [WIDTH-1:0] q_reg, d_reg, r_reg;
    logic [WIDTH-1:0] q_step, r_step;
    logic [CNT_W-1:0] cnt;
    logic             sign_q, sign_r;
    logic [WIDTH-1:0] out0_reg, out1_reg;
    logic             done_reg, div0_reg;

    logic             start, step_en, fix_wr;
    logic             divisor_zero;
    logic [WIDTH-1:0] mag0, mag1;

    // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
    assign mag0         = bus.in0[WIDTH-1] ? -bus.in0 : bus.in0;
    assign mag1         = bus.in1[WIDTH-1] ? -bus.in1 : bus.in1;
    assign divisor_zero = (bus.in1 == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (r_step),
        .q_next (q_step)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next = state;
        if (!bus.control) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_next = divisor_zero ? DONE : RUN;
                RUN:     if (cnt == LAST_STEP) state_next = FIX;
                FIX:     state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        start   = 1'b0;
        step_en = 1'b0;
        fix_wr  = 1'b0;
        if (bus.control) begin
            unique case (state)
                IDLE:    start   = 1'b1;
                RUN:     step_en = 1'b1;
                FIX:     fix_wr  = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            q_reg    <= '0;
            d_reg    <= '0;
            r_reg    <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            out0_reg <= '0;
            out1_reg <= '0;
            done_reg <= 1'b0;
            div0_reg <= 1'b0;
        end else if (!bus.control) begin
            // Abort/release: status and working registers clear, results are retained.
            q_reg    <= '0;
            d_reg    <= '0;
            r_reg    <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            done_reg <= 1'b0;
            div0_reg <= 1'b0;
        end else if (start) begin
            q_reg  <= mag0;
            d_reg  <= mag1;
            r_reg  <= '0;
            cnt    <= '0;
            sign_q <= bus.in0[WIDTH-1] ^ bus.in1[WIDTH-1];
            sign_r <= bus.in0[WIDTH-1];
            if (divisor_zero) begin
                done_reg <= 1'b1;
                div0_reg <= 1'b1;
            end
        end else if (step_en) begin
            r_reg <= r_step;
            q_reg <= q_step;
            cnt   <= cnt + 1'b1;
        end else if (fix_wr) begin
            out1_reg <= sign_q ? -q_reg : q_reg;
            out0_reg <= sign_r ? -r_reg : r_reg;
            done_reg <= 1'b1;
        end
    end

    assign bus.out0 = out0_reg;
    assign bus.out1 = out1_reg;
    assign bus.done = done_reg;
    assign bus.div0 = div0_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed DIV cases, abort/reset behaviour and random
// signed pairs checked against a truncating-division reference computed with 64-bit arithmetic.
module tb_div_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] exp_q;
    logic [31:0] exp_r;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lq = sa / sb;
        lr = sa % sb;
        q  = 32'(lq);
        r  = 32'(lr);
    endfunction

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after edge k, with the operands already scrambled.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in0     = a;
        bus.in1     = b;
        bus.control = 1'b1;
        @(posedge clk);
        #1;
        bus.in0 = $urandom;
        bus.in1 = $urandom;
    endtask

    task automatic stop_div;
        bus.control = 1'b0;
        wait_edges(1);
    endtask

    task automatic test_reset;
        logic [65:0] got;
        reset       = 1'b1;
        bus.control = 1'b0;
        bus.in0     = '0;
        bus.in1     = '0;
        wait_edges(3);
        got = {bus.done, bus.div0, bus.out1, bus.out0};
        n_cmp++;
        if (got !== 66'd0) begin
            n_err++;
            $display("FAIL reset_values: got %h, want 0", got);
        end
        bus.control = 1'b1;
        bus.in0     = 32'd10;
        bus.in1     = 32'd0;
        wait_edges(2);
        got = {bus.done, bus.div0, bus.out1, bus.out0};
        n_cmp++;
        if (got !== 66'd0) begin
            n_err++;
            $display("FAIL reset_over_control: got %h, want 0", got);
        end
        bus.control = 1'b0;
        reset       = 1'b0;
        wait_edges(1);
        exp_q = '0;
        exp_r = '0;
    endtask

    task automatic test_basic;
        logic [65:0] got, want;
        start_div(32'd100, 32'd7);
        wait_edges(32);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early_done: done=%b at edge k+32, want 0", bus.done);
        end
        wait_edges(1);
        exp_q = 32'd14;
        exp_r = 32'd2;
        want  = {2'b10, exp_q, exp_r};
        got   = {bus.done, bus.div0, bus.out1, bus.out0};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL basic_100_7: got %h, want %h", got, want);
        end
        wait_edges(5);
        got = {bus.done, bus.div0, bus.out1, bus.out0};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL basic_hold: got %h, want %h", got, want);
        end
        stop_div();
        want = {2'b00, exp_q, exp_r};
        got  = {bus.done, bus.div0, bus.out1, bus.out0};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL basic_release: got %h, want %h", got, want);
        end
    endtask

    task automatic test_signs;
        logic [31:0] a_tab [3] = '{32'hFFFF_FFF9, 32'd7,         32'h8000_0000};
        logic [31:0] b_tab [3] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] q_tab [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
        logic [31:0] r_tab [3] = '{32'hFFFF_FFFF, 32'd1,         32'd0};
        logic [65:0] got, want;
        for (int i = 0; i < 3; i++) begin
            start_div(a_tab[i], b_tab[i]);
            wait_edges(33);
            exp_q = q_tab[i];
            exp_r = r_tab[i];
            want  = {2'b10, exp_q, exp_r};
            got   = {bus.done, bus.div0, bus.out1, bus.out0};
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL signs_%0d (%h/%h): got %h, want %h", i, a_tab[i], b_tab[i], got, want);
            end
            stop_div();
        end
    endtask

    task automatic test_div0;
        logic [65:0] got, want;
        start_div(32'd5, 32'd0);
        want = {2'b11, exp_q, exp_r};
        got  = {bus.done, bus.div0, bus.out1, bus.out0};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL div0_flag: got %h, want %h", got, want);
        end
        wait_edges(3);
        got = {bus.done, bus.div0, bus.out1, bus.out0};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL div0_hold: got %h, want %h", got, want);
        end
        stop_div();
        want = {2'b00, exp_q, exp_r};
        got  = {bus.done, bus.div0, bus.out1, bus.out0};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL div0_release: got %h, want %h", got, want);
        end
    endtask

    task automatic test_abort;
        logic [65:0] got, want;
        logic        seen_done;
        start_div(32'd100, 32'd7);
        wait_edges(9);
        bus.control = 1'b0;
        seen_done   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wait_edges(1);
            if (bus.done) seen_done = 1'b1;
        end
        want = {1'b0, exp_q, exp_r};
        got  = {seen_done, bus.out1, bus.out0};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL abort_run: got %h, want %h", got, want);
        end
        start_div(32'd1000, 32'd3);
        wait_edges(32);
        bus.control = 1'b0;
        wait_edges(1);
        got = {bus.done, bus.out1, bus.out0};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL abort_fix: got %h, want %h", got, want);
        end
        wait_edges(3);
        start_div(32'd9, 32'd3);
        wait_edges(33);
        exp_q = 32'd3;
        exp_r = 32'd0;
        want  = {2'b10, exp_q, exp_r};
        got   = {bus.done, bus.div0, bus.out1, bus.out0};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL after_abort_9_3: got %h, want %h", got, want);
        end
        stop_div();
    endtask

    task automatic test_reset_mid;
        logic [65:0] got, want;
        start_div(32'd123456, 32'hFFFF_FCEB);
        wait_edges(19);
        reset = 1'b1;
        wait_edges(1);
        exp_q = '0;
        exp_r = '0;
        got   = {bus.done, bus.div0, bus.out1, bus.out0};
        n_cmp++;
        if (got !== 66'd0) begin
            n_err++;
            $display("FAIL reset_mid_op: got %h, want 0", got);
        end
        wait_edges(2);
        // Control stays high through reset; the first edge after release must start afresh.
        bus.in0 = 32'd200;
        bus.in1 = 32'd9;
        reset   = 1'b0;
        wait_edges(1);
        bus.in0 = $urandom;
        bus.in1 = $urandom;
        wait_edges(33);
        exp_q = 32'd22;
        exp_r = 32'd2;
        want  = {2'b10, exp_q, exp_r};
        got   = {bus.done, bus.div0, bus.out1, bus.out0};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL reset_then_200_9: got %h, want %h", got, want);
        end
        stop_div();
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [65:0] got, want;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 20))
                                                            : 32'($urandom_range(1, 20));
            if (i % 8 == 5) a = 32'h8000_0000;
            if (b == 32'd0) b = 32'd1;
            start_div(a, b);
            wait_edges(33);
            ref_div(a, b, exp_q, exp_r);
            want = {2'b10, exp_q, exp_r};
            got  = {bus.done, bus.div0, bus.out1, bus.out0};
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL random_%0d (%h/%h): got %h, want %h", i, a, b, got, want);
            end
            stop_div();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div0();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
